// File: rtl/stim_byte_player.sv
// Script-driven byte stimulus player with a capture FIFO for DUT transmit bytes.
// The script engine replays SEND/WAIT/NOP/END ops as one-cycle byte strobes. The
// capture side runs on its own and keeps line and overflow counts.
module stim_byte_player #(
  parameter int DATA_W    = 8,
  parameter int PAY_W     = 16,
  parameter int DEPTH     = 64,
  parameter int GAP       = 1,
  parameter int CAP_DEPTH = 16,
  parameter int STRIP_CR  = 1
) (
  input  logic                     clk12m,
  input  logic                     tb_sim_rst,
  input  logic                     scr_we,
  input  logic [$clog2(DEPTH)-1:0] scr_addr,
  input  logic [PAY_W+1:0]         scr_wdata,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        tb_rx_data,
  output logic                     tb_rx_data_rdy,
  input  logic [DATA_W-1:0]        la_tx_data,
  input  logic                     la_tx_data_rdy,
  input  logic                     cap_rd,
  output logic [DATA_W-1:0]        cap_data,
  output logic                     cap_empty,
  output logic                     cap_full,
  output logic [7:0]               ovf_cnt,
  output logic [15:0]              line_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CAP_DEPTH);

  localparam logic [1:0] OP_SEND = 2'b00;
  localparam logic [1:0] OP_WAIT = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;

  // state is the debug view of the player; checkers can bind to it directly
  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_HOLD, S_GAP, S_WAIT, S_DONE
  } state_t;

  state_t            state;
  logic [AW-1:0]     pc;
  logic [PAY_W+1:0]  scr_mem [DEPTH];
  logic [PAY_W+1:0]  cur;
  logic [1:0]        cur_op;
  logic [PAY_W-1:0]  cur_pay;
  logic [PAY_W-1:0]  wait_cnt;
  logic [7:0]        gap_cnt;
  logic              last_pc;

  // Outcome of "advance to the next entry": the last entry acts as an implicit END
  state_t            adv_state;
  logic [AW-1:0]     adv_pc;
  logic              adv_busy;
  logic              adv_done;

  assign cur     = scr_mem[pc];
  assign cur_op  = cur[PAY_W+1:PAY_W];
  assign cur_pay = cur[PAY_W-1:0];
  assign last_pc = (pc == AW'(DEPTH - 1));

  assign adv_state = last_pc ? S_DONE : S_EXEC;
  assign adv_pc    = last_pc ? pc : pc + 1'b1;
  assign adv_busy  = ~last_pc;
  assign adv_done  = last_pc;

  // Script memory: synchronous write while idle, never reset so scripts survive reset
  always_ff @(posedge clk12m) begin
    if (scr_we && !busy) scr_mem[scr_addr] <= scr_wdata;
  end

  // Player FSM with registered busy/done/strobe outputs
  always_ff @(posedge clk12m or posedge tb_sim_rst) begin
    if (tb_sim_rst) begin
      state          <= S_IDLE;
      pc             <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      tb_rx_data_rdy <= 1'b0;
      tb_rx_data     <= '0;
      wait_cnt       <= '0;
      gap_cnt        <= '0;
    end else begin
      done           <= 1'b0;
      tb_rx_data_rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_EXEC;
            busy  <= 1'b1;
          end
        end
        S_EXEC: begin
          case (cur_op)
            OP_SEND: begin
              state          <= S_HOLD;
              tb_rx_data_rdy <= 1'b1;
              tb_rx_data     <= cur_pay[DATA_W-1:0];
            end
            OP_WAIT: begin
              if (cur_pay == '0) begin
                state <= adv_state; pc <= adv_pc; busy <= adv_busy; done <= adv_done;
              end else begin
                state    <= S_WAIT;
                wait_cnt <= cur_pay;
              end
            end
            OP_NOP: begin
              state <= adv_state; pc <= adv_pc; busy <= adv_busy; done <= adv_done;
            end
            default: begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          endcase
        end
        S_HOLD: begin
          if (GAP == 0) begin
            state <= adv_state; pc <= adv_pc; busy <= adv_busy; done <= adv_done;
          end else begin
            state   <= S_GAP;
            gap_cnt <= 8'(GAP);
          end
        end
        S_GAP: begin
          if (gap_cnt <= 8'd1) begin
            state <= adv_state; pc <= adv_pc; busy <= adv_busy; done <= adv_done;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        S_WAIT: begin
          if (wait_cnt <= PAY_W'(1)) begin
            state <= adv_state; pc <= adv_pc; busy <= adv_busy; done <= adv_done;
          end else begin
            wait_cnt <= wait_cnt - PAY_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          pc    <= '0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Capture FIFO: circular buffer that keeps one slot free, so it holds CAP_DEPTH-1 bytes
  logic [DATA_W-1:0] cap_mem [CAP_DEPTH];
  logic [CW-1:0]     wr_ptr, rd_ptr, wr_nxt;
  logic              is_cr, is_lf, push_req, pop, push, drop;

  assign wr_nxt    = wr_ptr + 1'b1;
  assign cap_empty = (wr_ptr == rd_ptr);
  assign cap_full  = (wr_nxt == rd_ptr);
  assign cap_data  = cap_mem[rd_ptr];

  assign is_cr    = (la_tx_data == DATA_W'(8'h0d));
  assign is_lf    = (la_tx_data == DATA_W'(8'h0a));
  assign push_req = la_tx_data_rdy && !((STRIP_CR != 0) && is_cr);
  assign pop      = cap_rd && !cap_empty;
  assign push     = push_req && (!cap_full || pop);
  assign drop     = push_req && cap_full && !pop;

  // Capture storage write
  always_ff @(posedge clk12m) begin
    if (push) cap_mem[wr_ptr] <= la_tx_data;
  end

  // Capture pointers, saturating overflow count and wrapping line count
  always_ff @(posedge clk12m or posedge tb_sim_rst) begin
    if (tb_sim_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_nxt;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop && ovf_cnt != 8'hff) ovf_cnt <= ovf_cnt + 8'd1;
      if (la_tx_data_rdy && is_lf) line_cnt <= line_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_stim_byte_player.sv
// Bench for stim_byte_player: script timing derived from per-op cycle costs, capture
// behaviour checked against a queue model of the FIFO and its counters.
module tb_stim_byte_player;
  localparam int DEPTH = 64;
  localparam int GAP   = 1;
  localparam int CAPM  = 15;
  localparam logic [1:0] SEND = 2'b00, WAIT = 2'b01, NOP = 2'b10, ENDOP = 2'b11;

  logic        clk12m = 1'b0;
  logic        tb_sim_rst;
  logic        scr_we;
  logic [5:0]  scr_addr;
  logic [17:0] scr_wdata;
  logic        start;
  logic        busy, done;
  logic [7:0]  tb_rx_data;
  logic        tb_rx_data_rdy;
  logic [7:0]  la_tx_data;
  logic        la_tx_data_rdy;
  logic        cap_rd;
  logic [7:0]  cap_data;
  logic        cap_empty, cap_full;
  logic [7:0]  ovf_cnt;
  logic [15:0] line_cnt;

  stim_byte_player dut (
    .clk12m(clk12m), .tb_sim_rst(tb_sim_rst), .scr_we(scr_we), .scr_addr(scr_addr),
    .scr_wdata(scr_wdata), .start(start), .busy(busy), .done(done),
    .tb_rx_data(tb_rx_data), .tb_rx_data_rdy(tb_rx_data_rdy),
    .la_tx_data(la_tx_data), .la_tx_data_rdy(la_tx_data_rdy), .cap_rd(cap_rd),
    .cap_data(cap_data), .cap_empty(cap_empty), .cap_full(cap_full),
    .ovf_cnt(ovf_cnt), .line_cnt(line_cnt)
  );

  // clock
  always #5 clk12m = ~clk12m;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [17:0] script_m [DEPTH];
  logic [7:0]  exp_q[$];
  int          exp_t_q[$];
  logic [7:0]  rx_hold = 8'h00;
  logic [7:0]  cap_q[$];
  logic [7:0]  ovf_m = 8'h00;
  logic [15:0] line_m = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference timing: EXEC is cycle t; SEND strobes at t+1 and costs 2+GAP,
  // WAIT n costs 1+n (n=0 costs 1), NOP 1, END 1 then done; after the last entry done.
  function automatic int build_model();
    int t = 0;
    exp_q.delete();
    exp_t_q.delete();
    for (int pc = 0; pc < DEPTH; pc++) begin
      case (script_m[pc][17:16])
        SEND: begin
          exp_q.push_back(script_m[pc][7:0]);
          exp_t_q.push_back(t + 1);
          t += 2 + GAP;
        end
        WAIT:  t += 1 + int'(script_m[pc][15:0]);
        NOP:   t += 1;
        default: return t + 1;
      endcase
    end
    return t;
  endfunction

  task automatic wr(input int a, input logic [1:0] op, input logic [15:0] p);
    @(negedge clk12m);
    scr_we = 1'b1;
    scr_addr = 6'(a);
    scr_wdata = {op, p};
    script_m[a] = {op, p};
  endtask

  task automatic wr_close();
    @(negedge clk12m);
    scr_we = 1'b0;
  endtask

  // Runs the loaded script and checks every cycle; poke=1 also tries a script write
  // and a second start while the player is busy, both of which must have no effect.
  task automatic run_script(input string tag, input bit poke);
    int  done_t;
    bit  exp_rdy;
    done_t = build_model();
    @(negedge clk12m);
    start = 1'b1;
    @(negedge clk12m);
    start = 1'b0;
    for (int k = 0; k <= done_t + 1; k++) begin
      exp_rdy = (exp_t_q.size() > 0) && (exp_t_q[0] == k);
      check({tag, ".rdy"}, 32'(tb_rx_data_rdy), 32'(exp_rdy));
      if (exp_rdy) begin
        check({tag, ".byte"}, 32'(tb_rx_data), 32'(exp_q[0]));
        rx_hold = exp_q.pop_front();
        void'(exp_t_q.pop_front());
      end
      check({tag, ".done"}, 32'(done), 32'(k == done_t));
      check({tag, ".busy"}, 32'(busy), 32'(k < done_t));
      if (poke) begin
        scr_we = (k == 1);
        scr_addr = 6'd0;
        scr_wdata = {SEND, 16'h00ee};
        start = (k == 3);
      end
      @(negedge clk12m);
    end
    scr_we = 1'b0;
    start = 1'b0;
    check({tag, ".strobes_left"}, 32'(exp_t_q.size()), 32'd0);
    check({tag, ".held_byte"}, 32'(tb_rx_data), 32'(rx_hold));
  endtask

  // One capture cycle: check current outputs against the model, drive, then update model
  task automatic cap_cycle(input logic v, input logic [7:0] d, input logic rd);
    bit p, psh;
    @(negedge clk12m);
    check("cap_empty", 32'(cap_empty), 32'(cap_q.size() == 0));
    check("cap_full", 32'(cap_full), 32'(cap_q.size() == CAPM));
    if (cap_q.size() > 0) check("cap_data", 32'(cap_data), 32'(cap_q[0]));
    check("ovf_cnt", 32'(ovf_cnt), 32'(ovf_m));
    check("line_cnt", 32'(line_cnt), 32'(line_m));
    la_tx_data_rdy = v;
    la_tx_data = d;
    cap_rd = rd;
    p = rd && (cap_q.size() > 0);
    psh = 1'b0;
    if (v) begin
      if (d == 8'h0a) line_m = line_m + 16'd1;
      if (d != 8'h0d) begin
        if (cap_q.size() == CAPM && !p) begin
          if (ovf_m != 8'hff) ovf_m = ovf_m + 8'd1;
        end else begin
          psh = 1'b1;
        end
      end
    end
    if (p) void'(cap_q.pop_front());
    if (psh) cap_q.push_back(d);
  endtask

  initial begin
    int target;
    logic [7:0] ab [4];
    logic [7:0] b;
    ab[0] = 8'h61; ab[1] = 8'h62; ab[2] = 8'h0d; ab[3] = 8'h0a;

    // reset
    tb_sim_rst = 1'b1;
    scr_we = 1'b0; scr_addr = '0; scr_wdata = '0; start = 1'b0;
    la_tx_data = '0; la_tx_data_rdy = 1'b0; cap_rd = 1'b0;
    repeat (3) @(negedge clk12m);
    tb_sim_rst = 1'b0;
    @(negedge clk12m);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.rdy", 32'(tb_rx_data_rdy), 32'd0);
    check("rst.data", 32'(tb_rx_data), 32'd0);
    check("rst.empty", 32'(cap_empty), 32'd1);
    check("rst.full", 32'(cap_full), 32'd0);
    check("rst.ovf", 32'(ovf_cnt), 32'd0);
    check("rst.lines", 32'(line_cnt), 32'd0);

    // 'L', eight '0', CR, END; writes and restarts while busy must be ignored
    wr(0, SEND, 16'h004c);
    for (int i = 1; i <= 8; i++) wr(i, SEND, 16'h0030);
    wr(9, SEND, 16'h000d);
    wr(10, ENDOP, 16'h0000);
    wr_close();
    run_script("send_seq", 1'b1);
    run_script("send_seq_again", 1'b0);

    // WAIT 3 and WAIT 0 between sends
    wr(0, SEND, 16'h0041);
    wr(1, WAIT, 16'd3);
    wr(2, SEND, 16'h0042);
    wr(3, WAIT, 16'd0);
    wr(4, SEND, 16'h0043);
    wr(5, NOP, 16'h0000);
    wr(6, ENDOP, 16'h0000);
    wr_close();
    run_script("wait_seq", 1'b0);

    // every entry a SEND, no END: implicit finish after the last entry
    for (int i = 0; i < DEPTH; i++) wr(i, SEND, 16'($urandom_range(0, 255)));
    wr_close();
    run_script("full_no_end", 1'b0);
    run_script("full_no_end_rerun", 1'b0);

    // random scripts
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int r = $urandom_range(0, 31);
        if (r == 0) wr(i, ENDOP, 16'($urandom_range(0, 65535)));
        else if (r < 16) wr(i, SEND, 16'($urandom_range(0, 65535)));
        else if (r < 24) wr(i, WAIT, 16'($urandom_range(0, 4)));
        else wr(i, NOP, 16'($urandom_range(0, 65535)));
      end
      wr_close();
      run_script($sformatf("rand%0d", s), 1'b0);
    end

    // reset while the second SEND strobe is up, then replay
    wr(0, SEND, 16'h0011);
    wr(1, WAIT, 16'd2);
    wr(2, SEND, 16'h0022);
    wr(3, SEND, 16'h0033);
    wr(4, ENDOP, 16'h0000);
    wr_close();
    void'(build_model());
    target = exp_t_q[1];
    @(negedge clk12m);
    start = 1'b1;
    @(negedge clk12m);
    start = 1'b0;
    repeat (target) @(negedge clk12m);
    check("midrst.pre_rdy", 32'(tb_rx_data_rdy), 32'd1);
    check("midrst.pre_data", 32'(tb_rx_data), 32'h22);
    #1 tb_sim_rst = 1'b1;
    #1;
    check("midrst.rdy", 32'(tb_rx_data_rdy), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.data", 32'(tb_rx_data), 32'd0);
    @(negedge clk12m);
    tb_sim_rst = 1'b0;
    rx_hold = 8'h00;
    cap_q.delete();
    ovf_m = 8'h00;
    line_m = 16'h0000;
    run_script("midrst_replay", 1'b0);

    // "ab\r\n" x5 with no reads: CRs stripped, FIFO fills, no overflow yet
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 4; i++) cap_cycle(1'b1, ab[i], 1'b0);
    cap_cycle(1'b0, 8'h00, 1'b0);
    check("ab.full", 32'(cap_full), 32'd1);
    check("ab.ovf", 32'(ovf_cnt), 32'd0);
    check("ab.lines", 32'(line_cnt), 32'd5);
    cap_cycle(1'b1, 8'h78, 1'b0);
    cap_cycle(1'b1, 8'h79, 1'b0);
    cap_cycle(1'b0, 8'h00, 1'b0);
    check("ab.ovf2", 32'(ovf_cnt), 32'd2);
    for (int i = 0; i < CAPM; i++) cap_cycle(1'b0, 8'h00, 1'b1);
    cap_cycle(1'b0, 8'h00, 1'b1);
    cap_cycle(1'b0, 8'h00, 1'b0);

    // refill, then pop and push in the same cycle while full
    for (int i = 0; i < CAPM; i++) begin
      b = 8'($urandom_range(16, 255));
      cap_cycle(1'b1, b, 1'b0);
    end
    cap_cycle(1'b1, 8'h5a, 1'b1);
    cap_cycle(1'b0, 8'h00, 1'b0);
    check("fullrw.full", 32'(cap_full), 32'd1);
    check("fullrw.ovf", 32'(ovf_cnt), 32'd2);
    for (int i = 0; i < CAPM; i++) cap_cycle(1'b0, 8'h00, 1'b1);

    // random capture traffic
    for (int i = 0; i < 300; i++) begin
      int sel = $urandom_range(0, 5);
      b = (sel == 0) ? 8'h0a : (sel == 1) ? 8'h0d : 8'($urandom_range(0, 255));
      cap_cycle(1'($urandom_range(0, 1)), b, ($urandom_range(0, 9) < 3));
    end
    cap_cycle(1'b0, 8'h00, 1'b0);
    cap_cycle(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
